mod_addsub_pipe: RTL and testbench



---
 rtl/mod_addsub_pipe.sv | 131 +++++++++++++
 tb/tb_mod_addsub_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract with valid/ready on both sides.
// Define MOD_ADDSUB_RANGE_CHECK_EN to flag out-of-range operands on out_err.
module mod_addsub_pipe #(
    parameter int N   = 4,
    parameter int MOD = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_s,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic         out_err
);

    localparam logic [N+1:0] MODX = (N+2)'(MOD);
    localparam logic [N-1:0] MODL = N'(MOD);

    logic         adv1;
    logic         adv2;

    logic [N:0]   a_x;
    logic [N:0]   b_x;
    logic [N:0]   w_add;
    logic [N:0]   w_sub;
    logic [N-1:0] v_add;
    logic [N-1:0] v_sub;
    logic         sel_add;
    logic         sel_sub;
    logic         err_c;

    logic         v1_q,   v1_d;
    logic [N-1:0] w1_q,   w1_d;
    logic [N-1:0] c1_q,   c1_d;
    logic         sel1_q, sel1_d;
    logic         err1_q, err1_d;

    logic         v2_q,   v2_d;
    logic [N-1:0] r2_q,   r2_d;
    logic         err2_q, err2_d;

    assign adv2     = !v2_q | out_ready;
    assign adv1     = !v1_q | adv2;
    assign in_ready = adv1;

    assign a_x   = {1'b0, in_a};
    assign b_x   = {1'b0, in_b};
    assign w_add = a_x + b_x;
    assign w_sub = a_x - b_x;

    // Only the low N bits of the corrected candidate ever reach out_r,
    // so the correction is done at N bits; the select uses full width.
    assign v_add   = w_add[N-1:0] - MODL;
    assign v_sub   = w_sub[N-1:0] + MODL;
    assign sel_add = {1'b0, w_add} >= MODX;
    assign sel_sub = w_sub[N];

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    assign err_c = ({2'b00, in_a} >= MODX) | ({2'b00, in_b} >= MODX);
`else
    assign err_c = 1'b0;
`endif

    always_comb begin
        v1_d   = v1_q;
        w1_d   = w1_q;
        c1_d   = c1_q;
        sel1_d = sel1_q;
        err1_d = err1_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                err1_d = err_c;
                if (in_s) begin
                    w1_d   = w_sub[N-1:0];
                    c1_d   = v_sub;
                    sel1_d = sel_sub;
                end else begin
                    w1_d   = w_add[N-1:0];
                    c1_d   = v_add;
                    sel1_d = sel_add;
                end
            end
        end
    end

    // Bubbles clear v2 but leave the result registers untouched.
    always_comb begin
        v2_d   = v2_q;
        r2_d   = r2_q;
        err2_d = err2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                r2_d   = sel1_q ? c1_q : w1_q;
                err2_d = err1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            w1_q   <= '0;
            c1_q   <= '0;
            sel1_q <= 1'b0;
            err1_q <= 1'b0;
            v2_q   <= 1'b0;
            r2_q   <= '0;
            err2_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            w1_q   <= w1_d;
            c1_q   <= c1_d;
            sel1_q <= sel1_d;
            err1_q <= err1_d;
            v2_q   <= v2_d;
            r2_q   <= r2_d;
            err2_q <= err2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_r     = r2_q;
    assign out_err   = err2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Randomised and directed bench for mod_addsub_pipe against a queue model.
module tb_mod_addsub_pipe;

    localparam int N   = 4;
    localparam int MOD = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_s;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_r;
    logic         out_err;

    int checks = 0;
    int errors = 0;
    int exp_r[$];
    bit exp_e[$];

    mod_addsub_pipe #(.N(N), .MOD(MOD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s     (in_s),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    function automatic int model_r(bit s, int a, int b);
        int t;
        if (!s) begin
            t = a + b;
            if (t >= MOD) t = t - MOD;
        end else begin
            t = a - b;
            if (t < 0) t = t + MOD;
        end
        return t & ((1 << N) - 1);
    endfunction

    function automatic bit model_e(int a, int b);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        return (a >= MOD) || (b >= MOD);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle, sample mid-cycle, return at posedge+1.
    task automatic step(input bit v, input bit s, input int a, input int b,
                        input bit ordy, output bit acc, output bit ov,
                        output bit rdy, output int r, output bit e);
        in_valid  = v;
        in_s      = s;
        in_a      = a[N-1:0];
        in_b      = b[N-1:0];
        out_ready = ordy;
        @(negedge clk);
        rdy = in_ready;
        acc = v && in_ready;
        ov  = out_valid;
        r   = int'(out_r);
        e   = out_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc, ov, rdy, e;
        int r;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, acc, ov, rdy, r, e);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", ov);
        end
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL reset_r got %0d want 0", r);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %0b want 0", e);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b want 1", rdy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        bit s_t[5] = '{0, 1, 1, 0, 0};
        int a_t[5] = '{7, 3, 9, 12, 6};
        int b_t[5] = '{9, 5, 9, 12, 7};
        int r_t[5] = '{3, 11, 0, 11, 0};
        bit acc, ov, rdy, e;
        int r;
        for (int i = 0; i < 5; i++) begin
            step(1, s_t[i], a_t[i], b_t[i], 1, acc, ov, rdy, r, e);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL dir_accept[%0d] got 0 want 1", i);
            end
            step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL dir_early[%0d] got valid %0b want 0", i, ov);
            end
            step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
            checks++;
            if (ov !== 1'b1 || r != r_t[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL dir_result[%0d] got v=%0b r=%0d e=%0b want v=1 r=%0d e=0",
                         i, ov, r, e, r_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ov, rdy, e, s;
        int r, a, b, got, first, last, cyc;
        got = 0; first = -1; last = -1; cyc = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 8) begin
                s = 1'($urandom_range(0, 1));
                a = $urandom_range(0, MOD - 1);
                b = $urandom_range(0, MOD - 1);
            end
            step(i < 8, s, a, b, 1, acc, ov, rdy, r, e);
            if (i < 8) begin
                checks++;
                if (!acc) begin
                    errors++;
                    $display("FAIL b2b_accept[%0d] got 0 want 1", i);
                end
            end
            if (ov) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got r=%0d want none", r);
                end else begin
                    if (r != exp_r[0] || e !== exp_e[0]) begin
                        errors++;
                        $display("FAIL b2b_data got r=%0d e=%0b want r=%0d e=%0b",
                                 r, e, exp_r[0], exp_e[0]);
                    end
                    void'(exp_r.pop_front());
                    void'(exp_e.pop_front());
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (acc) begin
                exp_r.push_back(model_r(s, a, b));
                exp_e.push_back(model_e(a, b));
            end
            cyc++;
        end
        checks++;
        if (got != 8 || last - first + 1 != 8 || first != 2) begin
            errors++;
            $display("FAIL b2b_stream got %0d results span %0d first %0d want 8 8 2",
                     got, last - first + 1, first);
        end
        exp_r.delete();
        exp_e.delete();
    endtask

    task automatic test_stall();
        bit acc, ov, rdy, e;
        int r, idx, got, held;
        bit s_b[4];
        int a_b[4];
        int b_b[4];
        idx = 0; got = 0; held = -1;
        for (int i = 0; i < 4; i++) begin
            s_b[i] = 1'($urandom_range(0, 1));
            a_b[i] = $urandom_range(0, MOD - 1);
            b_b[i] = $urandom_range(0, MOD - 1);
        end
        for (int i = 0; i < 6; i++) begin
            step(idx < 4, s_b[idx % 4], a_b[idx % 4], b_b[idx % 4], 0,
                 acc, ov, rdy, r, e);
            if (ov) begin
                if (held < 0) held = r;
                checks++;
                if (r != held) begin
                    errors++;
                    $display("FAIL stall_hold got %0d want %0d", r, held);
                end
            end
            if (acc) begin
                exp_r.push_back(model_r(s_b[idx], a_b[idx], b_b[idx]));
                exp_e.push_back(model_e(a_b[idx], b_b[idx]));
                idx++;
            end
        end
        checks++;
        if (idx != 2 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_fill got accepted %0d ready %0b want 2 0", idx, rdy);
        end
        for (int i = 0; i < 20 && (idx < 4 || exp_r.size() > 0); i++) begin
            step(idx < 4, s_b[idx % 4], a_b[idx % 4], b_b[idx % 4], 1,
                 acc, ov, rdy, r, e);
            if (ov) begin
                got++;
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra got r=%0d want none", r);
                end else begin
                    if (r != exp_r[0] || e !== exp_e[0]) begin
                        errors++;
                        $display("FAIL stall_data got r=%0d want r=%0d", r, exp_r[0]);
                    end
                    void'(exp_r.pop_front());
                    void'(exp_e.pop_front());
                end
            end
            if (acc) begin
                exp_r.push_back(model_r(s_b[idx], a_b[idx], b_b[idx]));
                exp_e.push_back(model_e(a_b[idx], b_b[idx]));
                idx++;
            end
        end
        checks++;
        if (got != 4 || exp_r.size() != 0) begin
            errors++;
            $display("FAIL stall_count got %0d left %0d want 4 0", got, exp_r.size());
        end
        exp_r.delete();
        exp_e.delete();
    endtask

    task automatic test_reset_flight();
        bit acc, ov, rdy, e;
        int r, seen;
        seen = 0;
        step(1, 0, 2, 3, 1, acc, ov, rdy, r, e);
        step(1, 1, 8, 4, 1, acc, ov, rdy, r, e);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, acc, ov, rdy, r, e);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
            if (ov) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_flight got %0d stale results want 0", seen);
        end
    endtask

    task automatic test_range();
        bit acc, ov, rdy, e;
        int r, k;
        step(1, 0, 14, 1, 1, acc, ov, rdy, r, e);
        k = 0;
        ov = 1'b0;
        while (!ov && k < 6) begin
            step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
            k++;
        end
        checks++;
        if (!ov || e !== model_e(14, 1) || r != model_r(0, 14, 1)) begin
            errors++;
            $display("FAIL range_add got v=%0b r=%0d e=%0b want v=1 r=%0d e=%0b",
                     ov, r, e, model_r(0, 14, 1), model_e(14, 1));
        end
        step(1, 1, 2, 15, 1, acc, ov, rdy, r, e);
        step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
        step(0, 0, 0, 0, 1, acc, ov, rdy, r, e);
        checks++;
        if (!ov || e !== model_e(2, 15) || r != model_r(1, 2, 15)) begin
            errors++;
            $display("FAIL range_sub got v=%0b r=%0d e=%0b want v=1 r=%0d e=%0b",
                     ov, r, e, model_r(1, 2, 15), model_e(2, 15));
        end
    endtask

    task automatic test_random();
        bit acc, ov, rdy, e, s, v, ordy, pstall;
        int r, a, b, pr;
        pstall = 1'b0; pr = 0;
        for (int i = 0; i < 330; i++) begin
            v    = (i < 300) && ($urandom_range(0, 9) < 7);
            ordy = (i >= 300) || ($urandom_range(0, 9) < 6);
            s    = 1'($urandom_range(0, 1));
            a    = $urandom_range(0, MOD - 1);
            b    = $urandom_range(0, MOD - 1);
            step(v, s, a, b, ordy, acc, ov, rdy, r, e);
            if (pstall) begin
                checks++;
                if (!ov || r != pr) begin
                    errors++;
                    $display("FAIL rnd_hold got v=%0b r=%0d want v=1 r=%0d", ov, r, pr);
                end
            end
            if (ov && ordy) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got r=%0d want none", r);
                end else begin
                    if (r != exp_r[0] || e !== exp_e[0]) begin
                        errors++;
                        $display("FAIL rnd_data got r=%0d e=%0b want r=%0d e=%0b",
                                 r, e, exp_r[0], exp_e[0]);
                    end
                    void'(exp_r.pop_front());
                    void'(exp_e.pop_front());
                end
            end
            pstall = ov && !ordy;
            pr = r;
            if (acc) begin
                exp_r.push_back(model_r(s, a, b));
                exp_e.push_back(model_e(a, b));
            end
        end
        checks++;
        if (exp_r.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain got %0d results missing want 0", exp_r.size());
        end
        exp_r.delete();
        exp_e.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_s      = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
